// File: rtl/scalar_pkg.sv
// rtl/scalar_pkg.sv - shared constants for the scalar processor boot memory
//
// Purpose: default bus widths, boot loader state encodings and the opcode
//   constants shared between the scalar processor, its boot memory and the bench.
// Ports: none (package).
package scalar_pkg;

  localparam int SCALAR_AW = 8;
  localparam int SCALAR_DW = 8;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_ERR     = 2'd3
  } ld_state_t;

  // Upper nibble of an instruction byte.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;

endpackage

// File: rtl/scalar_ram.sv
// rtl/scalar_ram.sv - DEPTH x DW array, one synchronous write port, one async read port
//
// Purpose: storage for the unified program/data memory. Contents have no reset.
// Ports:
//   clk    in   clock, writes on posedge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  combinational read data
module scalar_ram
  import scalar_pkg::*;
#(
  parameter int AW = SCALAR_AW,
  parameter int DW = SCALAR_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/scalar_boot_mem.sv
// rtl/scalar_boot_mem.sv - boot-loaded 256x8 program/data memory for the scalar processor
//
// Purpose: after reset, holds the processor in reset and writes a valid/ready byte
//   stream to consecutive addresses from 00h; then releases the core and serves
//   its shared read/write bus.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   ld_valid/ld_data    loader byte stream, ld_last marks the final byte
//   ld_ready            loader may transfer this cycle
//   reload              pulse in RUN/ERR restarts loading at 00h
//   cpu_rst             processor reset (high = held)
//   addr, dat, rd, wrt  processor bus; dat is bidirectional
//   load_cnt            bytes accepted in the current load
//   load_err            image overflowed the memory without ld_last
module scalar_boot_mem
  import scalar_pkg::*;
#(
  parameter int AW             = SCALAR_AW,
  parameter int DW             = SCALAR_DW,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          reload,
  output logic          cpu_rst,
  input  logic [AW-1:0] addr,
  inout  logic [DW-1:0] dat,
  input  logic          rd,
  input  logic          wrt,
  output logic [AW:0]   load_cnt,
  output logic          load_err
);

  localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  ld_state_t     state, state_nx;
  logic [AW:0]   cnt_nx;
  logic [RW-1:0] rel_cnt, rel_nx;
  logic          xfer;
  logic          cpu_rd, cpu_wr;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata, rdata;

  assign ld_ready = (state == ST_LOAD) && !rst;
  assign cpu_rst  = (state != ST_RUN);
  assign load_err = (state == ST_ERR);
  assign xfer     = ld_valid && ld_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_LOAD;
      load_cnt <= '0;
      rel_cnt  <= '0;
    end else begin
      state    <= state_nx;
      load_cnt <= cnt_nx;
      rel_cnt  <= rel_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = load_cnt;
    rel_nx   = rel_cnt;
    case (state)
      ST_LOAD: begin
        if (xfer) begin
          cnt_nx = load_cnt + (AW+1)'(1);
          if (ld_last) begin
            state_nx = ST_RELEASE;
            rel_nx   = RW'(RELEASE_CYCLES - 1);
          end else if (&load_cnt[AW-1:0]) begin
            // This was the byte at the top address; the count lands on DEPTH and stops.
            state_nx = ST_ERR;
          end
        end
      end
      ST_RELEASE: begin
        if (rel_cnt == '0) begin
          state_nx = ST_RUN;
        end else begin
          rel_nx = rel_cnt - RW'(1);
        end
      end
      ST_RUN, ST_ERR: begin
        if (reload) begin
          state_nx = ST_LOAD;
          cnt_nx   = '0;
        end
      end
      default: state_nx = ST_LOAD;
    endcase
  end

  // Conflicting or idle strobes leave the bus floating and suppress the write.
  assign cpu_rd = (state == ST_RUN) && rd && !wrt;
  assign cpu_wr = (state == ST_RUN) && wrt && !rd;

  // The loader owns the write port only while loading; the core owns it otherwise.
  assign we    = xfer || cpu_wr;
  assign waddr = (state == ST_LOAD) ? load_cnt[AW-1:0] : addr;
  assign wdata = (state == ST_LOAD) ? ld_data : dat;

  scalar_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (addr),
    .rdata (rdata)
  );

  assign dat = cpu_rd ? rdata : {DW{1'bz}};

endmodule

// File: tb/tb_scalar_boot_mem.sv
// tb/tb_scalar_boot_mem.sv - self-checking bench for scalar_boot_mem
module tb_scalar_boot_mem;
  import scalar_pkg::*;

  localparam int REL = 2;

  logic       clk = 1'b0;
  logic       rst, ld_valid, ld_last, reload, rd, wrt;
  logic       ld_ready, cpu_rst, load_err;
  logic [7:0] ld_data, addr;
  logic [8:0] load_cnt;
  wire  [7:0] dat;
  logic       tb_drv;
  logic [7:0] tb_dat;

  assign dat = tb_drv ? tb_dat : 8'hzz;

  scalar_boot_mem #(
    .AW             (8),
    .DW             (8),
    .RELEASE_CYCLES (REL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .reload   (reload),
    .cpu_rst  (cpu_rst),
    .addr     (addr),
    .dat      (dat),
    .rd       (rd),
    .wrt      (wrt),
    .load_cnt (load_cnt),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: memory image plus the phase of the boot sequence.
  logic [7:0] m_mem [256];
  bit         m_known [256];
  int         m_cnt;
  bit         m_loading, m_running, m_err;
  int         m_rel_left;

  bit         exp_ready, exp_cpu_rst, exp_err, exp_dat_valid;
  int         exp_cnt;
  logic [7:0] exp_dat;
  bit         chk_en = 1'b0;

  function automatic void model_reset();
    m_cnt      = 0;
    m_loading  = 1'b1;
    m_running  = 1'b0;
    m_err      = 1'b0;
    m_rel_left = 0;
  endfunction

  // Applies one rising edge with the inputs currently on the pins.
  function automatic void model_edge();
    if (rst) return;
    if (m_loading) begin
      if (ld_valid) begin
        m_mem[m_cnt]   = ld_data;
        m_known[m_cnt] = 1'b1;
        m_cnt++;
        if (ld_last) begin
          m_loading  = 1'b0;
          m_rel_left = REL;
        end else if (m_cnt == 256) begin
          m_loading = 1'b0;
          m_err     = 1'b1;
        end
      end
    end else if (m_err) begin
      if (reload) begin
        m_err     = 1'b0;
        m_loading = 1'b1;
        m_cnt     = 0;
      end
    end else if (m_running) begin
      if (wrt && !rd) begin
        m_mem[addr]   = tb_dat;
        m_known[addr] = 1'b1;
      end
      if (reload) begin
        m_running = 1'b0;
        m_loading = 1'b1;
        m_cnt     = 0;
      end
    end else begin
      m_rel_left--;
      if (m_rel_left == 0) m_running = 1'b1;
    end
  endfunction

  function automatic void compute_exp();
    exp_ready   = m_loading && !rst;
    exp_cpu_rst = !m_running;
    exp_err     = m_err;
    exp_cnt     = m_cnt;
    if (m_running && rd && !wrt) begin
      exp_dat       = m_mem[addr];
      exp_dat_valid = m_known[addr];
    end else begin
      // DUT must not drive: the bus shows only what the bench drives.
      exp_dat       = tb_dat;
      exp_dat_valid = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("ld_ready", 32'(ld_ready), 32'(exp_ready));
      check("cpu_rst", 32'(cpu_rst), 32'(exp_cpu_rst));
      check("load_err", 32'(load_err), 32'(exp_err));
      check("load_cnt", 32'(load_cnt), 32'(exp_cnt));
      if (exp_dat_valid) check("dat", 32'(dat), 32'(exp_dat));
    end
  end

  task automatic cyc(input bit r, input bit lv, input logic [7:0] ld, input bit ll,
                     input bit rl, input logic [7:0] a, input bit rdi, input bit wri,
                     input logic [7:0] wd);
    @(posedge clk);
    model_edge();
    #1;
    rst = r; ld_valid = lv; ld_data = ld; ld_last = ll; reload = rl;
    addr = a; rd = rdi; wrt = wri;
    if (r) model_reset();
    tb_drv = !(m_running && rdi && !wri);
    tb_dat = (wri && !rdi) ? wd : 8'h00;
    compute_exp();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();                          cyc(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00); endtask
  task automatic ld_byte(input logic [7:0] d, input bit last); cyc(0, 1, d, last, 0, 8'h00, 0, 0, 8'h00); endtask
  task automatic bus_rd(input logic [7:0] a);     cyc(0, 0, 8'h00, 0, 0, a, 1, 0, 8'h00); endtask
  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d); cyc(0, 0, 8'h00, 0, 0, a, 0, 1, d); endtask
  task automatic do_reload();                     cyc(0, 0, 8'h00, 0, 1, 8'h00, 0, 0, 8'h00); endtask
  task automatic settle();
    for (int i = 0; i < REL + 1; i++) idle();
  endtask

  logic [7:0] img [48];

  initial begin
    rst = 1'b1; ld_valid = 0; ld_data = 0; ld_last = 0; reload = 0;
    addr = 0; rd = 0; wrt = 0; tb_drv = 1'b1; tb_dat = 8'h00;
    model_reset();
    compute_exp();
    chk_en = 1'b1;

    // Reset state
    cyc(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00);
    cyc(1, 1, 8'h77, 0, 0, 8'h00, 0, 0, 8'h00);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_load_cnt", 32'(load_cnt), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    idle();
    check("load_ready", 32'(ld_ready), 32'd1);

    // Two-byte image and release timing
    ld_byte(8'h55, 0);
    ld_byte(8'h48, 1);
    idle();
    check("t1_cnt", 32'(load_cnt), 32'd2);
    check("t1_rst_edge0", 32'(cpu_rst), 32'd1);
    idle();
    check("t1_rst_edge1", 32'(cpu_rst), 32'd1);
    idle();
    check("t1_rst_edge2", 32'(cpu_rst), 32'd0);
    bus_rd(8'h00);
    check("t1_mem00", 32'(dat), 32'h55);
    bus_rd(8'h01);
    check("t1_mem01", 32'(dat), 32'h48);

    // Bus read/write, idle and conflicting strobes
    bus_wr(8'h80, 8'h44);
    bus_rd(8'h80);
    check("t2_rd80", 32'(dat), 32'h44);
    cyc(0, 0, 8'h00, 0, 0, 8'h80, 0, 0, 8'h00);
    check("t2_idle_z", 32'(dat), 32'h00);
    bus_wr(8'h81, 8'h99);
    cyc(0, 0, 8'h00, 0, 0, 8'h81, 1, 1, 8'h00);
    check("t3_both_z", 32'(dat), 32'h00);
    bus_rd(8'h81);
    check("t3_rd81", 32'(dat), 32'h99);

    // Random processor traffic
    for (int i = 0; i < 200; i++)
      cyc(0, $urandom_range(0, 1), 8'($urandom), 0, 0, 8'($urandom_range(0, 63) + 8'h60),
          $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom));

    // Reload, reset mid-load, retention
    do_reload();
    idle();
    check("t5_reload_ready", 32'(ld_ready), 32'd1);
    check("t5_reload_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t5_reload_cnt", 32'(load_cnt), 32'd0);
    ld_byte(8'hAA, 0);
    ld_byte(8'hBB, 0);
    ld_byte(8'hCC, 0);
    cyc(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00);
    check("t5_rst_cnt", 32'(load_cnt), 32'd0);
    check("t5_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    idle();
    ld_byte(8'h11, 1);
    settle();
    bus_rd(8'h01);
    check("t5_keep01", 32'(dat), 32'hBB);
    bus_rd(8'h02);
    check("t5_keep02", 32'(dat), 32'hCC);

    // Overflow without ld_last
    do_reload();
    for (int i = 0; i < 256; i++) ld_byte(8'(i) ^ 8'h5A, 0);
    idle();
    check("t4_err", 32'(load_err), 32'd1);
    check("t4_cnt", 32'(load_cnt), 32'h100);
    check("t4_ready", 32'(ld_ready), 32'd0);
    check("t4_cpu_rst", 32'(cpu_rst), 32'd1);
    do_reload();
    idle();
    check("t4_err_clr", 32'(load_err), 32'd0);
    ld_byte(8'h33, 1);
    settle();
    bus_rd(8'hFF);
    check("t4_memff", 32'(dat), 32'hA5);
    bus_rd(8'h01);
    check("t4_mem01", 32'(dat), 32'h5B);

    // Full flow: 48-byte four-task program, then the task-1 store
    for (int i = 0; i < 48; i++) begin
      case (i % 6)
        0:       img[i] = {OP_LD, 4'(i)};
        1:       img[i] = {OP_ADD, 4'(i)};
        2:       img[i] = {OP_ST, 4'(i)};
        3:       img[i] = {OP_JMP, 4'(i)};
        default: img[i] = {OP_NOP, 4'(i)};
      endcase
    end
    do_reload();
    for (int i = 0; i < 48; i++) ld_byte(img[i], i == 47);
    idle();
    check("t6_cnt", 32'(load_cnt), 32'd48);
    settle();
    bus_wr(8'h80, 8'h89);
    bus_rd(8'h80);
    check("t6_mem80", 32'(dat), 32'h89);
    bus_rd(8'h2F);
    check("t6_mem2f", 32'(dat), 32'h0F);

    // Randomized mix of loads, releases, traffic, reloads and resets
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
          $urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0,
          8'($urandom_range(0, 63)), $urandom_range(0, 1), $urandom_range(0, 1),
          8'($urandom));

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
